// File: rtl/multiword_addsub_pkg.sv
// multiword_addsub_pkg: shared FSM state type, mode encoding and index-width helper.
package multiword_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_addsub_slice.sv
// addsub_slice: combinational BITS-wide add/subtract slice; subtract inverts y and relies on cin=1.
module addsub_slice
  import multiword_addsub_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] x_i,
  input  logic [BITS-1:0] y_i,
  input  logic            mode_i,
  input  logic            cin_i,
  output logic [BITS-1:0] sum_o,
  output logic            cout_o
);

  logic [BITS-1:0] y_eff;

  assign y_eff = y_i ^ {BITS{mode_i == MODE_SUB}};
  assign {cout_o, sum_o} = {1'b0, x_i} + {1'b0, y_eff} + {{BITS{1'b0}}, cin_i};

endmodule

// File: rtl/multiword_addsub.sv
// multiword_addsub: word-serial multi-precision add/sub, LSW first, one slice time-multiplexed.
// Optional ADDSUB_SAT_EN saturates the result on signed overflow.
module multiword_addsub
  import multiword_addsub_pkg::*;
#(
  parameter  int BITS  = 8,
  parameter  int WORDS = 4,
  localparam int W     = BITS * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int IW = idx_w(WORDS);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, mode_q, mode_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [BITS-1:0] x, y, sum;
  logic            s_cout, c_msb, ovf_w, last;

  assign x = a_q[int'(idx_q)*BITS +: BITS];
  assign y = b_q[int'(idx_q)*BITS +: BITS];

  addsub_slice #(.BITS(BITS)) u_slice (
    .x_i   (x),
    .y_i   (y),
    .mode_i(mode_q),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(s_cout)
  );

  // Carry into the MSB recovered from the sum bit and the effective operand bits.
  assign c_msb = sum[BITS-1] ^ x[BITS-1] ^ y[BITS-1] ^ (mode_q == MODE_SUB);
  assign ovf_w = c_msb ^ s_cout;
  assign last  = idx_q == IW'(WORDS - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    if (state_q == RUN) begin
      res_d[int'(idx_q)*BITS +: BITS] = sum;
      carry_d = s_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_d  = s_cout;
        ovf_d   = ovf_w;
        state_d = DONE;
`ifdef ADDSUB_SAT_EN
        if (ovf_w) res_d = sum[BITS-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
      end
    end else if (start) begin
      a_d     = a;
      b_d     = b;
      mode_d  = mode;
      carry_d = mode != MODE_ADD;
      idx_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign busy     = state_q == RUN;
  assign done     = state_q == DONE;
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_addsub.sv
// tb_multiword_addsub: directed scoreboard bench for multiword_addsub (BITS=8, WORDS=4).
module tb_multiword_addsub;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, cout, overflow;
  logic [31:0] result;
  int          passed = 0, total = 0;
  exp_t        sb[$];

  multiword_addsub #(.BITS(8), .WORDS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic m);
    exp_t        e;
    logic [31:0] ye;
    logic [32:0] s;
    ye  = m ? ~y : y;
    s   = {1'b0, x} + {1'b0, ye} + {32'd0, m};
    e.r = s[31:0];
    e.c = s[32];
    e.v = (x[31] == ye[31]) && (s[31] != x[31]);
`ifdef ADDSUB_SAT_EN
    if (e.v) e.r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic m, input bit push);
    a = x;
    b = y;
    mode = m;
    start = 1'b1;
    if (push) sb.push_back(model(x, y, m));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (done !== 1'b1 && lat < 20) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"}, result, e.r);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.v});
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic m, input string tag);
    int lat, bc;
    drive(x, y, m, 1'b1);
    wait_done(1, lat, bc);
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_cycles"}, bc, 4);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check_out(tag);
  endtask

  initial begin
    int lat, bc, dcnt;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, "add_ff_1");
    chk("add_ff_1_const", result, 32'h0000_0100);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b1, "sub_0_1");
    @(negedge clk);
    do_op(32'h0000_0005, 32'h0000_0003, 1'b1, "sub_5_3");
    chk("sub_5_3_const", result, 32'h0000_0002);
    @(negedge clk);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_pos_ovf");
    @(negedge clk);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, "sub_neg_ovf");
    @(negedge clk);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add_ripple");
    chk("add_ripple_const", result, 32'h0000_0000);
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, "back_to_back");
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      @(negedge clk);
    end

    drive(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1, 1'b0);
    wait_done(3, lat, bc);
    chk("ignore_latency", lat, 5);
    check_out("ignore_start");
    @(negedge clk);

    drive(32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    chk("abort_no_done", dcnt, 0);
    do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, "after_abort");
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
